// File: rtl/alu_control_pipe.sv
// Registered ALU control for the RV32IM pipeline at the ID/EX boundary.
// Single-cycle ops complete on accept; M-extension ops run a latency sequencer that stalls decode.
module alu_control_pipe #(
  parameter int M_EN    = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       VALID_IN,
  input  logic [2:0] ALUOP,
  input  logic [2:0] FUNCT3,
  input  logic       FUNCT7_5,
  input  logic       FUNCT7_0,
  input  logic       STALL_IN,
  input  logic       FLUSH,
  output logic [4:0] ALUSELECT,
  output logic       VALID_OUT,
  output logic       MD_START,
  output logic       BUSY,
  output logic       ILLEGAL
);

  // state   | meaning
  // S_IDLE  | accepting decode-stage instructions
  // S_MD    | mul/div in flight, BUSY held until the latency count expires

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MD   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    alusel_q, alusel_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          ill_q, ill_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]    dec_code;
  logic          dec_illegal;
  logic          dec_is_md;

  always_comb begin
    dec_code    = 5'b00000;
    dec_illegal = 1'b0;
    dec_is_md   = 1'b0;
    case (ALUOP)
      3'b000: begin
        if (FUNCT7_0) begin
          if (M_EN != 0) begin
            dec_code  = {2'b10, FUNCT3};
            dec_is_md = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (FUNCT7_5) begin
          // only SUB and SRA carry instr[30]=1
          if (FUNCT3 == 3'b000 || FUNCT3 == 3'b101) begin
            dec_code = {2'b01, FUNCT3};
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_code = {2'b00, FUNCT3};
        end
      end
      3'b001: begin
        if (FUNCT3 == 3'b101 && FUNCT7_5) begin
          dec_code = 5'b01101;
        end else begin
          dec_code = {2'b00, FUNCT3};
        end
      end
      3'b100: begin
        case (FUNCT3)
          3'b000:  dec_code = 5'b01000;
          3'b001:  dec_code = 5'b01001;
          3'b100:  dec_code = 5'b01010;
          3'b101:  dec_code = 5'b01011;
          3'b110:  dec_code = 5'b01100;
          3'b111:  dec_code = 5'b01110;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_code = 5'b00000;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    alusel_d = alusel_q;
    valid_d  = valid_q;
    start_d  = 1'b0;
    busy_d   = busy_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    if (FLUSH) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      ill_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          if (!STALL_IN) begin
            if (VALID_IN) begin
              alusel_d = dec_code;
              ill_d    = dec_illegal;
              if (dec_is_md) begin
                valid_d = 1'b0;
                start_d = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = FUNCT3[2] ? DIV_INIT : MUL_INIT;
                state_d = S_MD;
              end else begin
                valid_d = 1'b1;
              end
            end else begin
              valid_d = 1'b0;
              ill_d   = 1'b0;
            end
          end
        end
        S_MD: begin
          valid_d = 1'b0;
          busy_d  = 1'b1;
          // count runs down even while stalled; only completion waits for STALL_IN
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (!STALL_IN) begin
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      alusel_q <= 5'b00000;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alusel_q <= alusel_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ALUSELECT = alusel_q;
  assign VALID_OUT = valid_q;
  assign MD_START  = start_q;
  assign BUSY      = busy_q;
  assign ILLEGAL   = ill_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Bench for alu_control_pipe: three parameterisations checked every cycle against an
// elapsed-edge behavioural model, plus directed literal expectations.
module tb_alu_control_pipe;

  localparam int NI = 3;
  localparam int P_MEN[NI] = '{1, 0, 1};
  localparam int P_MUL[NI] = '{2, 2, 1};
  localparam int P_DIV[NI] = '{32, 32, 3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [2:0] aluop = 3'b000;
  logic [2:0] funct3 = 3'b000;
  logic       f75 = 1'b0;
  logic       f70 = 1'b0;
  logic       stall_in = 1'b0;
  logic       flush = 1'b0;

  logic [4:0] sel_w [NI];
  logic       vld_w [NI];
  logic       start_w [NI];
  logic       busy_w [NI];
  logic       ill_w [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_control_pipe #(.M_EN(1), .MUL_LAT(2), .DIV_LAT(32)) dut0 (
    .CLK(clk), .RST_N(rst_n), .VALID_IN(valid_in), .ALUOP(aluop), .FUNCT3(funct3),
    .FUNCT7_5(f75), .FUNCT7_0(f70), .STALL_IN(stall_in), .FLUSH(flush),
    .ALUSELECT(sel_w[0]), .VALID_OUT(vld_w[0]), .MD_START(start_w[0]), .BUSY(busy_w[0]),
    .ILLEGAL(ill_w[0]));

  alu_control_pipe #(.M_EN(0), .MUL_LAT(2), .DIV_LAT(32)) dut1 (
    .CLK(clk), .RST_N(rst_n), .VALID_IN(valid_in), .ALUOP(aluop), .FUNCT3(funct3),
    .FUNCT7_5(f75), .FUNCT7_0(f70), .STALL_IN(stall_in), .FLUSH(flush),
    .ALUSELECT(sel_w[1]), .VALID_OUT(vld_w[1]), .MD_START(start_w[1]), .BUSY(busy_w[1]),
    .ILLEGAL(ill_w[1]));

  alu_control_pipe #(.M_EN(1), .MUL_LAT(1), .DIV_LAT(3)) dut2 (
    .CLK(clk), .RST_N(rst_n), .VALID_IN(valid_in), .ALUOP(aluop), .FUNCT3(funct3),
    .FUNCT7_5(f75), .FUNCT7_0(f70), .STALL_IN(stall_in), .FLUSH(flush),
    .ALUSELECT(sel_w[2]), .VALID_OUT(vld_w[2]), .MD_START(start_w[2]), .BUSY(busy_w[2]),
    .ILLEGAL(ill_w[2]));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_dec(input int men, input logic [2:0] op, input logic [2:0] f3,
                                  input logic a5, input logic a0,
                                  output int code, output bit ill, output bit md);
    int bcode[8];
    bcode = '{8, 9, 0, 0, 10, 11, 12, 14};
    code = 0; ill = 0; md = 0;
    if (op == 3'd0) begin
      if (a0) begin
        if (men != 0) begin code = 16 + int'(f3); md = 1; end
        else ill = 1;
      end else if (!a5) code = int'(f3);
      else if (f3 == 3'd0) code = 8;
      else if (f3 == 3'd5) code = 13;
      else ill = 1;
    end else if (op == 3'd1) begin
      code = (f3 == 3'd5 && a5) ? 13 : int'(f3);
    end else if (op == 3'd4) begin
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
      else code = bcode[f3];
    end
  endfunction

  // model: an M op finishes at the first unstalled edge at least LAT edges after accept
  int m_sel [NI];
  bit m_vld [NI];
  bit m_start [NI];
  bit m_busy [NI];
  bit m_ill [NI];
  int m_elapsed [NI];
  int m_lat [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_sel[i] = 0; m_vld[i] = 0; m_start[i] = 0; m_busy[i] = 0; m_ill[i] = 0;
        m_elapsed[i] = 0; m_lat[i] = 0;
      end else begin
        int code; bit ill; bit md;
        m_start[i] = 0;
        ref_dec(P_MEN[i], aluop, funct3, f75, f70, code, ill, md);
        if (flush) begin
          m_vld[i] = 0; m_busy[i] = 0; m_ill[i] = 0;
        end else if (m_busy[i]) begin
          m_elapsed[i]++;
          if (m_elapsed[i] >= m_lat[i] && !stall_in) begin
            m_busy[i] = 0; m_vld[i] = 1;
          end
        end else if (stall_in) begin
          // hold
        end else if (valid_in) begin
          m_sel[i] = code;
          m_ill[i] = ill;
          if (md) begin
            m_vld[i] = 0; m_start[i] = 1; m_busy[i] = 1; m_elapsed[i] = 0;
            m_lat[i] = funct3[2] ? P_DIV[i] : P_MUL[i];
          end else begin
            m_vld[i] = 1;
          end
        end else begin
          m_vld[i] = 0; m_ill[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("cyc%0d valid_out", i), int'(vld_w[i]), int'(m_vld[i]));
        chk($sformatf("cyc%0d busy", i), int'(busy_w[i]), int'(m_busy[i]));
        chk($sformatf("cyc%0d md_start", i), int'(start_w[i]), int'(m_start[i]));
        if (m_vld[i]) begin
          chk($sformatf("cyc%0d aluselect", i), int'(sel_w[i]), m_sel[i]);
          chk($sformatf("cyc%0d illegal", i), int'(ill_w[i]), int'(m_ill[i]));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                       input logic a5, input logic a0, input logic st, input logic fl);
    valid_in = v; aluop = op; funct3 = f3; f75 = a5; f70 = a0; stall_in = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm, input int i);
    chk({nm, " sel"}, int'(sel_w[i]), 0);
    chk({nm, " valid"}, int'(vld_w[i]), 0);
    chk({nm, " start"}, int'(start_w[i]), 0);
    chk({nm, " busy"}, int'(busy_w[i]), 0);
    chk({nm, " illegal"}, int'(ill_w[i]), 0);
  endtask

  initial begin
    int rises;
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    #12;
    chk_all_zero("reset", 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // SUB
    drive(1, 3'd0, 3'd0, 1, 0, 0, 0); tick();
    chk("sub sel", int'(sel_w[0]), 5'b01000);
    chk("sub valid", int'(vld_w[0]), 1);
    chk("sub illegal", int'(ill_w[0]), 0);
    drive(1, 3'd1, 3'd5, 1, 0, 0, 0); tick();
    chk("srai sel", int'(sel_w[0]), 5'b01101);
    drive(1, 3'd4, 3'd6, 0, 0, 0, 0); tick();
    chk("bltu sel", int'(sel_w[0]), 5'b01100);
    drive(1, 3'd4, 3'd2, 0, 0, 0, 0); tick();
    chk("b010 illegal", int'(ill_w[0]), 1);
    chk("b010 sel", int'(sel_w[0]), 0);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    chk("idle valid", int'(vld_w[0]), 0);

    // DIV, 32 edges, VALID_IN toggling while busy
    drive(1, 3'd0, 3'd4, 0, 1, 0, 0); tick();
    chk("div start", int'(start_w[0]), 1);
    chk("div busy0", int'(busy_w[0]), 1);
    chk("div valid0", int'(vld_w[0]), 0);
    chk("div sel0", int'(sel_w[0]), 5'b10100);
    for (int k = 1; k < 32; k++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      tick();
      chk("div busy mid", int'(busy_w[0]), 1);
      chk("div valid mid", int'(vld_w[0]), 0);
      chk("div start mid", int'(start_w[0]), 0);
    end
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    chk("div valid32", int'(vld_w[0]), 1);
    chk("div sel32", int'(sel_w[0]), 5'b10100);
    chk("div busy32", int'(busy_w[0]), 0);
    tick(); tick(); tick(); tick();

    // MUL with stall on edges 1..4
    drive(1, 3'd0, 3'd0, 0, 1, 0, 0); tick();
    chk("mul start", int'(start_w[0]), 1);
    chk("men0 illegal", int'(ill_w[1]), 1);
    chk("men0 busy", int'(busy_w[1]), 0);
    chk("men0 start", int'(start_w[1]), 0);
    chk("men0 sel", int'(sel_w[1]), 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 3'd0, 3'd0, 0, 0, 1, 0); tick();
      chk("mul stall busy", int'(busy_w[0]), 1);
      chk("mul stall valid", int'(vld_w[0]), 0);
    end
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    chk("mul valid", int'(vld_w[0]), 1);
    chk("mul sel", int'(sel_w[0]), 5'b10000);
    chk("mul busy", int'(busy_w[0]), 0);
    tick(); tick(); tick(); tick();

    // DIV aborted by FLUSH at edge 10
    drive(1, 3'd0, 3'd5, 0, 1, 0, 0); tick();
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) tick();
    chk("flush pre busy", int'(busy_w[0]), 1);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 1); tick();
    chk("flush busy", int'(busy_w[0]), 0);
    chk("flush valid", int'(vld_w[0]), 0);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    chk("post flush valid", int'(vld_w[0]), 0);
    drive(1, 3'd0, 3'd0, 0, 0, 0, 0); tick();
    chk("add valid", int'(vld_w[0]), 1);
    chk("add sel", int'(sel_w[0]), 0);
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vld_w[0]) rises++;
    end
    chk("no valid after abort", rises, 0);

    // async reset mid-MD
    drive(1, 3'd0, 3'd4, 0, 1, 0, 0); tick();
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0); tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async reset", 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 9) < 7), 3'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2),
            1'($urandom_range(0, 99) < 5));
      tick();
    end
    drive(0, 3'd0, 3'd0, 0, 0, 0, 0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
